// File: rtl/aead_serial_loader.sv
// Purpose: buffers key/nonce/AD/plaintext words, then shifts them MSB-first into a serial AEAD core.
// Latency: start output rises N+1 cycles after the last word is accepted (N shift + 1 settle).
// Backpressure: in_ready is high only in LOAD and DONE; words offered in any other state are ignored.
module aead_serial_loader #(
  parameter int          K    = 128,
  parameter int          L    = 40,
  parameter int          Y    = 40,
  parameter int          W    = 32,
  parameter logic [31:0] SEED = 32'hACE1_2024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         mode_dec,
  output logic         aead_rstn,
  output logic         keyxSO,
  output logic         noncexSO,
  output logic         adxSO,
  output logic         ptxSO,
  output logic         r128xSO,
  output logic         rptxSO,
  output logic         enc_startxSO,
  output logic         dec_startxSO,
  input  logic         enc_readyxSI,
  input  logic         dec_readyxSI,
  output logic         busy,
  output logic         done
);

  localparam int NB  = 128;
  localparam int KW  = (K + W - 1) / W;
  localparam int NW  = NB / W;
  localparam int AW  = (L + W - 1) / W;
  localparam int PW  = (Y + W - 1) / W;
  localparam int TW  = KW + NW + AW + PW;
  localparam int N1  = (K > NB) ? K : NB;
  localparam int N2  = (L > Y) ? L : Y;
  localparam int N   = (N1 > N2) ? N1 : N2;
  localparam int WCW = $clog2(TW + 1);
  localparam int CW  = $clog2(N);

  // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  // One-hot MSB masks used to pick the current bit out of a left-shifted field
  localparam logic [K-1:0]  KEY_MSB   = {1'b1, {(K-1){1'b0}}};
  localparam logic [NB-1:0] NONCE_MSB = {1'b1, {(NB-1){1'b0}}};
  localparam logic [L-1:0]  AD_MSB    = {1'b1, {(L-1){1'b0}}};
  localparam logic [Y-1:0]  PT_MSB    = {1'b1, {(Y-1){1'b0}}};

  typedef enum logic [2:0] {
    S_LOAD   = 3'd0,
    S_SHIFT  = 3'd1,
    S_SETTLE = 3'd2,
    S_START  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [WCW-1:0]  wcnt;
  logic [WCW-1:0]  widx;
  logic [CW-1:0]   cnt;
  logic            mode;
  logic            rstn_q;
  logic [K-1:0]    key_r;
  logic [NB-1:0]   nonce_r;
  logic [L-1:0]    ad_r;
  logic [Y-1:0]    pt_r;
  logic [31:0]     lfsr;
  logic [31:0]     lfsr_nxt;
  logic            accept;
  logic            last_word;
  logic            start_ack;

  // A word from DONE always begins a fresh job, so it lands in word slot 0
  assign accept    = in_valid && in_ready;
  assign widx      = (state == S_DONE) ? '0 : wcnt;
  assign last_word = (wcnt == WCW'(TW - 1));
  assign start_ack = mode ? dec_readyxSI : enc_readyxSI;
  assign lfsr_nxt  = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_POLY : 32'h0);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_LOAD;
    else     state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD:   if (accept && last_word) state_nxt = S_SHIFT;
      S_SHIFT:  if (cnt == CW'(N - 1))   state_nxt = S_SETTLE;
      S_SETTLE: state_nxt = S_START;
      S_START:  if (start_ack)           state_nxt = S_DONE;
      S_DONE:   if (accept)              state_nxt = S_LOAD;
      default:  state_nxt = S_LOAD;
    endcase
  end

  // Word/bit counters, mode latch, field packing, LFSR and the registered core reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt    <= '0;
      cnt     <= '0;
      mode    <= 1'b0;
      rstn_q  <= 1'b0;
      key_r   <= '0;
      nonce_r <= '0;
      ad_r    <= '0;
      pt_r    <= '0;
      lfsr    <= SEED;
    end else begin
      rstn_q <= (state_nxt != S_LOAD);

      if (accept) begin
        if (state == S_DONE)  wcnt <= WCW'(1);
        else if (last_word)   wcnt <= '0;
        else                  wcnt <= wcnt + WCW'(1);

        if (widx == '0) mode <= mode_dec;

        if (widx < WCW'(KW))                key_r   <= K'({key_r, in_data});
        else if (widx < WCW'(KW + NW))      nonce_r <= NB'({nonce_r, in_data});
        else if (widx < WCW'(KW + NW + AW)) ad_r    <= L'({ad_r, in_data});
        else                                pt_r    <= Y'({pt_r, in_data});
      end

      if (state == S_SHIFT) begin
        cnt  <= (cnt == CW'(N - 1)) ? '0 : cnt + CW'(1);
        lfsr <= lfsr_nxt;
      end else begin
        cnt  <= '0;
      end
    end
  end

  // Output decode; a field shifted past its width reads as 0
  always_comb begin
    in_ready     = (state == S_LOAD) || (state == S_DONE);
    aead_rstn    = rstn_q;
    busy         = (state == S_SHIFT) || (state == S_SETTLE) || (state == S_START);
    done         = (state == S_DONE);
    keyxSO       = 1'b0;
    noncexSO     = 1'b0;
    adxSO        = 1'b0;
    ptxSO        = 1'b0;
    r128xSO      = 1'b0;
    rptxSO       = 1'b0;
    enc_startxSO = 1'b0;
    dec_startxSO = 1'b0;
    if (state == S_SHIFT) begin
      keyxSO   = |((key_r << cnt) & KEY_MSB);
      noncexSO = |((nonce_r << cnt) & NONCE_MSB);
      adxSO    = |((ad_r << cnt) & AD_MSB);
      ptxSO    = |((pt_r << cnt) & PT_MSB);
      r128xSO  = lfsr[0];
      rptxSO   = lfsr[1];
    end
    if (state == S_START) begin
      enc_startxSO = !mode;
      dec_startxSO = mode;
    end
  end

endmodule

// File: tb/tb_aead_serial_loader.sv
// Directed bench for aead_serial_loader: field replay, LFSR stream, start handshake,
// reset in mid-shift and back-to-back jobs started from DONE.
module tb_aead_serial_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mode_dec;
  logic        aead_rstn;
  logic        keyxSO, noncexSO, adxSO, ptxSO, r128xSO, rptxSO;
  logic        enc_startxSO, dec_startxSO;
  logic        enc_readyxSI, dec_readyxSI;
  logic        busy, done;

  int errors = 0;
  int checks = 0;

  logic [31:0] words [12] = '{
    32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF,
    32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10,
    32'h000000A5, 32'h5A5A5A5A,
    32'h0000003C, 32'h12345678
  };

  localparam logic [127:0] EXP_KEY   = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] EXP_NONCE = 128'h01020304_05060708_090A0B0C_0D0E0F10;
  localparam logic [127:0] EXP_AD    = {40'hA55A5A5A5A, 88'h0};
  localparam logic [127:0] EXP_PT    = {40'h3C12345678, 88'h0};
  localparam logic [31:0]  SEED      = 32'hACE1_2024;

  logic [127:0] key_obs, nonce_obs, ad_obs, pt_obs;
  logic [31:0]  r_obs, rp_obs, r_exp, rp_exp;

  aead_serial_loader dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode_dec(mode_dec), .aead_rstn(aead_rstn), .keyxSO(keyxSO), .noncexSO(noncexSO),
    .adxSO(adxSO), .ptxSO(ptxSO), .r128xSO(r128xSO), .rptxSO(rptxSO),
    .enc_startxSO(enc_startxSO), .dec_startxSO(dec_startxSO),
    .enc_readyxSI(enc_readyxSI), .dec_readyxSI(dec_readyxSI), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference Galois LFSR x^32+x^22+x^2+x+1, shifting toward bit 0
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    logic [31:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 32'h80200003;
    return n;
  endfunction

  task automatic build_lfsr_exp();
    logic [31:0] s;
    s = SEED;
    for (int i = 0; i < 32; i++) begin
      r_exp[31-i]  = s[0];
      rp_exp[31-i] = s[1];
      s = lfsr_step(s);
    end
  endtask

  // Called just after a rising edge; offers one word and holds it across exactly one edge
  task automatic send(input logic [31:0] d, input logic m);
    in_data  = d;
    mode_dec = m;
    in_valid = 1'b1;
    @(negedge clk);
    check("in_ready_load", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    mode_dec = ~m;
  endtask

  task automatic gap(input int n);
    for (int g = 0; g < n; g++) begin
      in_valid = 1'b0;
      in_data  = $urandom;
      @(posedge clk);
      #1;
    end
  endtask

  // Words before slot 0 carry the opposite mode to show only word 0's mode is kept
  task automatic load_job(input logic m, input int first);
    for (int i = first; i < 12; i++) begin
      send(words[i], (i == 0) ? m : ~m);
      if (i < 11) gap($urandom_range(0, 2));
    end
  endtask

  // Samples all 128 shift cycles while offering garbage words that must be ignored
  task automatic shift_capture(input logic chk_lfsr);
    in_valid = 1'b1;
    in_data  = 32'hFFFF_FFFF;
    for (int c = 0; c < 128; c++) begin
      @(negedge clk);
      if (c == 0) begin
        check("rstn_rise", aead_rstn, 1'b1);
        check("busy_shift", busy, 1'b1);
        check("in_ready_shift", in_ready, 1'b0);
      end
      key_obs   = {key_obs[126:0], keyxSO};
      nonce_obs = {nonce_obs[126:0], noncexSO};
      ad_obs    = {ad_obs[126:0], adxSO};
      pt_obs    = {pt_obs[126:0], ptxSO};
      if (c < 32) begin
        r_obs  = {r_obs[30:0], r128xSO};
        rp_obs = {rp_obs[30:0], rptxSO};
      end
    end
    in_valid = 1'b0;
    check("key_replay", key_obs, EXP_KEY);
    check("nonce_replay", nonce_obs, EXP_NONCE);
    check("ad_replay", ad_obs, EXP_AD);
    check("pt_replay", pt_obs, EXP_PT);
    if (chk_lfsr) begin
      build_lfsr_exp();
      check("r128_seq", r_obs, r_exp);
      check("rpt_seq", rp_obs, rp_exp);
    end
  endtask

  task automatic settle_start(input logic m);
    @(negedge clk);
    check("settle_busy", busy, 1'b1);
    check("settle_start", {enc_startxSO, dec_startxSO}, 2'b00);
    check("settle_serial", {keyxSO, noncexSO, adxSO, ptxSO, r128xSO, rptxSO}, 6'b0);
    @(negedge clk);
    check("start_enc", enc_startxSO, !m);
    check("start_dec", dec_startxSO, m);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; mode_dec = 1'b0;
    enc_readyxSI = 1'b0; dec_readyxSI = 1'b0;
    #2;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_rstn", aead_rstn, 1'b0);
    check("rst_busy_done", {busy, done}, 2'b00);
    check("rst_serial", {keyxSO, noncexSO, adxSO, ptxSO, r128xSO, rptxSO}, 6'b0);
    check("rst_start", {enc_startxSO, dec_startxSO}, 2'b00);
    @(posedge clk); #1; rst = 1'b0;

    // Job 1: encrypt, gapped valid in LOAD
    load_job(1'b0, 0);
    shift_capture(1'b1);
    settle_start(1'b0);
    dec_readyxSI = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    check("start_hold_enc", enc_startxSO, 1'b1);
    check("start_in_ready", in_ready, 1'b0);
    check("start_not_done", done, 1'b0);
    dec_readyxSI = 1'b0; in_valid = 1'b0; enc_readyxSI = 1'b1;
    @(negedge clk);
    enc_readyxSI = 1'b0;
    check("done1", done, 1'b1);
    check("done1_start", {enc_startxSO, dec_startxSO}, 2'b00);
    check("done1_rstn", aead_rstn, 1'b1);
    check("done1_ready_busy", {in_ready, busy}, 2'b10);
    @(posedge clk); #1;

    // Job 2: decrypt, started from DONE; 11 more words reach SHIFT
    send(words[0], 1'b1);
    check("newjob_done", done, 1'b0);
    check("newjob_rstn", aead_rstn, 1'b0);
    load_job(1'b1, 1);
    shift_capture(1'b0);
    settle_start(1'b1);
    for (int i = 0; i < 20; i++) begin
      enc_readyxSI = (i == 10);
      @(negedge clk);
      check("dec_wait", {dec_startxSO, enc_startxSO, done}, 3'b100);
    end
    enc_readyxSI = 1'b0; dec_readyxSI = 1'b1;
    @(negedge clk);
    dec_readyxSI = 1'b0;
    check("done2", done, 1'b1);
    check("done2_start", {enc_startxSO, dec_startxSO}, 2'b00);

    // Job 3: fresh reset, LFSR restarts from seed, then reset at c=60
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    load_job(1'b0, 0);
    for (int c = 0; c <= 60; c++) begin
      @(negedge clk);
      if (c < 32) r_obs = {r_obs[30:0], r128xSO};
    end
    build_lfsr_exp();
    check("r128_seq_job3", r_obs, r_exp);
    check("busy_c60", busy, 1'b1);
    #2; rst = 1'b1; #1;
    check("midrst_rstn", aead_rstn, 1'b0);
    check("midrst_state", {in_ready, busy, done}, 3'b100);
    check("midrst_serial", {keyxSO, noncexSO, adxSO, ptxSO, r128xSO, rptxSO}, 6'b0);
    @(posedge clk); #1; rst = 1'b0;

    // Job 4: complete job after the abort
    load_job(1'b0, 0);
    shift_capture(1'b1);
    settle_start(1'b0);
    enc_readyxSI = 1'b1;
    @(negedge clk);
    enc_readyxSI = 1'b0;
    check("done4", done, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aead_serial_loader.md
Name: aead_serial_loader

Overview:
- Upstream feeder for the serial-input AEAD core.
- Accepts key, nonce, associated data and plaintext as W-bit words over a valid/ready interface and buffers them.
- Holds the core in reset while loading, then releases it and shifts all fields out MSB-first on parallel 1-bit lines, together with LFSR random bits.
- After a settle cycle, raises the encryption or decryption start and waits for the core's ready.

Parameters:
- K, 128, key length in bits
- L, 40, associated-data length in bits
- Y, 40, plaintext length in bits
- W, 32, input word width
- SEED, 32'hACE1_2024, LFSR reset value (must be nonzero)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_data  in  W  input word
- in_valid  in  1  word valid
- in_ready  out  1  loader accepts word
- mode_dec  in  1  0=encrypt, 1=decrypt; sampled with first word of a job
- aead_rstn  out  1  active-low reset to the AEAD core
- keyxSO  out  1  key serial bit
- noncexSO  out  1  nonce serial bit
- adxSO  out  1  associated-data serial bit
- ptxSO  out  1  plaintext serial bit
- r128xSO  out  1  random bit for the 128-bit mask
- rptxSO  out  1  random bit for the plaintext mask
- enc_startxSO  out  1  encryption start (level)
- dec_startxSO  out  1  decryption start (level)
- enc_readyxSI  in  1  core encryption ready
- dec_readyxSI  in  1  core decryption ready
- busy  out  1  high in SHIFT, SETTLE and START
- done  out  1  high in DONE

Behaviour:
- Word counts:
  - KW = ceil(K/W), NW = 128/W, AW = ceil(L/W), PW = ceil(Y/W).
  - TW = KW+NW+AW+PW (12 at defaults).
  - Words arrive in fixed order: key, nonce, AD, plaintext.
- Packing:
  - Each field register F bits wide: on accept, field <= low F bits of {field, in_data}.
  - The first word of a field therefore carries its MSBs right-aligned; surplus high bits are discarded.
- Handshake: transfer occurs when in_valid && in_ready on a rising clk edge; in_ready is combinational from state.
- N = max(K, 128, L, Y).
- Reset (async):
  - state = LOAD, word counter 0, bit counter 0, all field registers 0, LFSR = SEED.
  - All outputs 0: aead_rstn=0, in_ready reads 1 (LOAD).
- State LOAD:
  - in_ready=1, aead_rstn=0, serial outputs 0.
  - Word counter increments per accept; mode_dec is latched on word 0.
  - On accept of word TW-1, go to SHIFT with bit counter c=0.
- State SHIFT (N cycles):
  - aead_rstn=1 (registered, rises on entry edge).
  - Per cycle c, each serial output = field[F-1-c] if c<F, else 0.
  - r128xSO and rptxSO are driven from the LFSR; the LFSR advances every SHIFT cycle.
  - At c=N-1, go to SETTLE.
- LFSR: 32-bit Galois, taps x^32+x^22+x^2+x+1. r128xSO = lfsr[0], rptxSO = lfsr[1].
- State SETTLE: exactly 1 cycle, serial outputs 0, then START. This lets the core's cycle counter exceed N.
- State START:
  - enc_startxSO=!mode, dec_startxSO=mode, held until the matching ready input is 1 at a clock edge.
  - Then both start outputs return to 0 and the state goes to DONE.
  - The non-matching ready input is ignored.
- State DONE:
  - done=1, aead_rstn stays 1 so the core streams its outputs; in_ready=1.
  - Accepting a word clears done, pulls aead_rstn to 0 on the same edge, stores that word as word 0 of a new job, and goes to LOAD with word counter 1.
- in_valid is ignored when in_ready=0; in_data is don't-care then.
- Latency: from last-word accept to the start output = N+1 cycles (N SHIFT + 1 SETTLE); start is high on cycle N+2.
- Reset mid-operation in any state: immediate return to the reset condition; the partial job is discarded and the LFSR is reseeded.

Test Plan:
- Reset, then 12 words: key 0x00112233..0xCCDDEEFF, nonce 0x01..., AD 0x000000A5 then 0x5A5A5A5A, PT 0x0000003C then 0x12345678, mode 0 -> aead_rstn rises on the edge after word 12. keyxSO replays key MSB-first over 128 cycles. adxSO outputs 0xA55A5A5A5A MSB-first, then 0 from c=40. enc_startxSO rises 129 cycles after the last accept.
- Same job with mode_dec=1; hold dec_readyxSI=0 for 20 cycles and pulse enc_readyxSI -> dec_startxSO stays high throughout and enc_startxSO stays 0. On dec_readyxSI=1, go to DONE with done=1.
- in_valid toggling randomly in LOAD -> only handshaken words are stored. in_valid during SHIFT/START -> in_ready=0 and registers unchanged.
- LFSR check: r128xSO sequence over the first 32 SHIFT cycles matches the reference Galois model from SEED. A second job after reset repeats the identical sequence.
- Assert rst at SHIFT c=60 -> all outputs 0 asynchronously, state LOAD. A full new job completes normally.
- From DONE, accept a new word -> done=0, aead_rstn=0 on the same edge. The new job needs only 11 more words before SHIFT.
